// File: rtl/mem_wb_load_stage_if.sv
// Bundle between the MEM stage / data memory and the load-completion stage,
// including the register-file write port and the stall request it returns.
interface mem_wb_load_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_is_load;
    logic [2:0]    in_load_sel;
    logic [1:0]    in_addr;
    logic [DW-1:0] in_rt_old;
    logic [DW-1:0] in_alu_res;
    logic          in_wen;
    logic [RW-1:0] in_waddr;
    logic          flush;
    logic          dm_rdata_valid;
    logic [DW-1:0] dm_rdata;
    logic          stall_req;
    logic          wb_valid;
    logic          wb_we;
    logic [RW-1:0] wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic [3:0]    wb_b_w_en;

    // Pipeline / memory side that feeds the stage and consumes writeback.
    modport master (
        output in_valid, in_is_load, in_load_sel, in_addr, in_rt_old,
               in_alu_res, in_wen, in_waddr, flush, dm_rdata_valid, dm_rdata,
        input  stall_req, wb_valid, wb_we, wb_waddr, wb_wdata, wb_b_w_en
    );

    // The load-completion stage itself.
    modport slave (
        input  in_valid, in_is_load, in_load_sel, in_addr, in_rt_old,
               in_alu_res, in_wen, in_waddr, flush, dm_rdata_valid, dm_rdata,
        output stall_req, wb_valid, wb_we, wb_waddr, wb_wdata, wb_b_w_en
    );
endinterface

// File: rtl/mem_wb_load_stage.sv
// Load-completion stage: waits for the data-memory response, aligns/extends
// the word (with lwl/lwr merge) and drives the register-file write port.
module mem_wb_load_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic                clk,
    input  logic                resetn,
    mem_wb_load_stage_if.slave  bus
);
    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;
    localparam logic [2:0] LD_LWL = 3'd5;
    localparam logic [2:0] LD_LWR = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state_reg, state_next;

    logic [2:0]    load_sel_reg;
    logic [1:0]    addr_reg;
    logic [DW-1:0] rt_old_reg;
    logic          wen_reg;
    logic [RW-1:0] waddr_reg;
    logic          capture;

    logic          wb_valid_reg, wb_valid_next;
    logic          wb_we_reg, wb_we_next;
    logic [RW-1:0] wb_waddr_reg, wb_waddr_next;
    logic [DW-1:0] wb_wdata_reg, wb_wdata_next;
    logic [3:0]    wb_b_w_en_reg, wb_b_w_en_next;

    // ---------------------------------------------------------------
    // Load data alignment
    // ---------------------------------------------------------------
    logic [7:0]    rd_byte [4];
    logic [7:0]    byte_pick;
    logic [15:0]   half_pick;
    logic [DW-1:0] lwl_shift, lwr_shift, part_shift, merged;
    logic [3:0]    lwl_mask, lwr_mask, part_mask;
    logic [DW-1:0] load_data;
    logic [3:0]    load_mask;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            assign rd_byte[gi] = bus.dm_rdata[8*gi +: 8];
            assign merged[8*gi +: 8] = part_mask[gi] ? part_shift[8*gi +: 8]
                                                     : rt_old_reg[8*gi +: 8];
        end
    endgenerate

    assign byte_pick = rd_byte[addr_reg];
    assign half_pick = addr_reg[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];

    // 3-a on a 2-bit address is simply its bitwise inverse.
    assign lwl_shift  = bus.dm_rdata << {addr_reg, 3'b000};
    assign lwr_shift  = bus.dm_rdata >> {~addr_reg, 3'b000};
    assign lwl_mask   = 4'b1111 << addr_reg;
    assign lwr_mask   = 4'b1111 >> (~addr_reg);
    assign part_shift = (load_sel_reg == LD_LWR) ? lwr_shift : lwl_shift;
    assign part_mask  = (load_sel_reg == LD_LWR) ? lwr_mask  : lwl_mask;

    always_comb begin
        load_data = bus.dm_rdata;
        load_mask = 4'b1111;
        case (load_sel_reg)
            LD_LB:  load_data = {{24{byte_pick[7]}}, byte_pick};
            LD_LBU: load_data = {24'h000000, byte_pick};
            LD_LH:  load_data = {{16{half_pick[15]}}, half_pick};
            LD_LHU: load_data = {16'h0000, half_pick};
            LD_LWL, LD_LWR: begin
                load_data = merged;
                load_mask = part_mask;
            end
            default: load_data = bus.dm_rdata;
        endcase
    end

    // ---------------------------------------------------------------
    // Control FSM and writeback next-state
    // ---------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        capture        = 1'b0;
        wb_valid_next  = 1'b0;
        wb_we_next     = 1'b0;
        wb_waddr_next  = wb_waddr_reg;
        wb_wdata_next  = wb_wdata_reg;
        wb_b_w_en_next = wb_b_w_en_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    if (bus.in_is_load) begin
                        capture    = 1'b1;
                        state_next = ST_WAIT;
                    end else begin
                        wb_valid_next  = 1'b1;
                        wb_we_next     = bus.in_wen;
                        wb_waddr_next  = bus.in_waddr;
                        wb_wdata_next  = bus.in_alu_res;
                        wb_b_w_en_next = 4'b1111;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.dm_rdata_valid) begin
                    state_next = ST_IDLE;
                    // A flush landing with the response discards the data.
                    if (!bus.flush) begin
                        wb_valid_next  = 1'b1;
                        wb_we_next     = wen_reg;
                        wb_waddr_next  = waddr_reg;
                        wb_wdata_next  = load_data;
                        wb_b_w_en_next = load_mask;
                    end
                end else if (bus.flush) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.dm_rdata_valid) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            load_sel_reg  <= 3'd0;
            addr_reg      <= 2'd0;
            rt_old_reg    <= '0;
            wen_reg       <= 1'b0;
            waddr_reg     <= '0;
            wb_valid_reg  <= 1'b0;
            wb_we_reg     <= 1'b0;
            wb_waddr_reg  <= '0;
            wb_wdata_reg  <= '0;
            wb_b_w_en_reg <= 4'b0000;
        end else begin
            state_reg     <= state_next;
            wb_valid_reg  <= wb_valid_next;
            wb_we_reg     <= wb_we_next;
            wb_waddr_reg  <= wb_waddr_next;
            wb_wdata_reg  <= wb_wdata_next;
            wb_b_w_en_reg <= wb_b_w_en_next;
            if (capture) begin
                load_sel_reg <= bus.in_load_sel;
                addr_reg     <= bus.in_addr;
                rt_old_reg   <= bus.in_rt_old;
                wen_reg      <= bus.in_wen;
                waddr_reg    <= bus.in_waddr;
            end
        end
    end

    assign bus.stall_req = (state_reg != ST_IDLE);
    assign bus.wb_valid  = wb_valid_reg;
    assign bus.wb_we     = wb_we_reg;
    assign bus.wb_waddr  = wb_waddr_reg;
    assign bus.wb_wdata  = wb_wdata_reg;
    assign bus.wb_b_w_en = wb_b_w_en_reg;
endmodule

// File: tb/tb_mem_wb_load_stage.sv
// Scoreboard bench for mem_wb_load_stage: expected writebacks are queued at
// stimulus time and compared whenever the stage pulses wb_valid.
module tb_mem_wb_load_stage;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_wb_load_stage_if #(.DW(32), .RW(5)) bus ();

    mem_wb_load_stage #(.DW(32), .RW(5)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  ben;
    } wb_t;

    wb_t exp_q[$];
    wb_t mon_e;
    int  n_checks = 0;
    int  n_errors = 0;
    int  n_txn    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: byte-wise view of the load result, independent of shifts.
    function automatic wb_t model_load(input logic [2:0] sel, input logic [1:0] a,
                                       input logic [31:0] rt, input logic [31:0] d,
                                       input logic wen, input logic [4:0] wa);
        wb_t r;
        logic [7:0]  b [4];
        logic [15:0] h;
        int          src;
        for (int k = 0; k < 4; k++) b[k] = d[8*k +: 8];
        h       = a[1] ? d[31:16] : d[15:0];
        r.we    = wen;
        r.waddr = wa;
        r.ben   = 4'hF;
        r.wdata = d;
        case (sel)
            3'd1: r.wdata = {{24{b[a][7]}}, b[a]};
            3'd2: r.wdata = {24'h0, b[a]};
            3'd3: r.wdata = {{16{h[15]}}, h};
            3'd4: r.wdata = {16'h0, h};
            3'd5: for (int k = 0; k < 4; k++) begin
                src = k - int'(a);
                r.ben[k] = (src >= 0);
                r.wdata[8*k +: 8] = (src >= 0) ? b[src] : rt[8*k +: 8];
            end
            3'd6: for (int k = 0; k < 4; k++) begin
                src = k + 3 - int'(a);
                r.ben[k] = (src <= 3);
                r.wdata[8*k +: 8] = (src <= 3) ? b[src] : rt[8*k +: 8];
            end
            default: r.wdata = d;
        endcase
        return r;
    endfunction

    // Writeback monitor: one line per completed transaction.
    always @(posedge clk) begin
        #1;
        if (bus.wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_wb_valid", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("wb_we",     bus.wb_we,     mon_e.we);
                check_val("wb_waddr",  bus.wb_waddr,  mon_e.waddr);
                check_val("wb_wdata",  bus.wb_wdata,  mon_e.wdata);
                check_val("wb_b_w_en", bus.wb_b_w_en, mon_e.ben);
                n_txn++;
                $display("txn %0d: waddr=%0d wdata=%h ben=%b we=%b",
                         n_txn, bus.wb_waddr, bus.wb_wdata, bus.wb_b_w_en, bus.wb_we);
            end
        end else if (bus.wb_we !== 1'b0) begin
            check_val("we_without_valid", bus.wb_we, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.in_valid       = 1'b0;
        bus.in_is_load     = 1'b0;
        bus.in_load_sel    = 3'd0;
        bus.in_addr        = 2'd0;
        bus.in_rt_old      = '0;
        bus.in_alu_res     = '0;
        bus.in_wen         = 1'b0;
        bus.in_waddr       = '0;
        bus.flush          = 1'b0;
        bus.dm_rdata_valid = 1'b0;
        bus.dm_rdata       = '0;
    endtask

    task automatic issue_nonload(input logic [31:0] alu, input logic [4:0] wa, input logic wen);
        bus.in_valid   = 1'b1;
        bus.in_is_load = 1'b0;
        bus.in_alu_res = alu;
        bus.in_waddr   = wa;
        bus.in_wen     = wen;
        exp_q.push_back('{wen, wa, alu, 4'hF});
        tick();
        bus.in_valid = 1'b0;
        check_val("nonload_valid", bus.wb_valid, 32'd1);
        check_val("nonload_stall", bus.stall_req, 32'd0);
    endtask

    // flush_at: wait-cycle index to flush in (waits = with the response, -1 = none)
    task automatic do_load(input logic [2:0] sel, input logic [1:0] a, input logic [31:0] rt,
                           input logic [31:0] d, input logic [4:0] wa, input logic wen,
                           input int waits, input int flush_at, input bit noise);
        bit killed;
        killed = (flush_at >= 0) && (flush_at <= waits);
        bus.in_valid    = 1'b1;
        bus.in_is_load  = 1'b1;
        bus.in_load_sel = sel;
        bus.in_addr     = a;
        bus.in_rt_old   = rt;
        bus.in_waddr    = wa;
        bus.in_wen      = wen;
        tick();
        bus.in_valid  = 1'b0;
        bus.in_rt_old = $urandom;
        bus.in_addr   = 2'($urandom);
        for (int i = 0; i < waits; i++) begin
            if (noise) begin
                bus.in_valid   = 1'($urandom);
                bus.in_is_load = 1'b0;
                bus.in_alu_res = $urandom;
                bus.in_wen     = 1'b1;
            end
            bus.dm_rdata = $urandom;
            bus.flush    = (i == flush_at);
            check_val("stall_wait", bus.stall_req, 32'd1);
            tick();
            bus.flush = 1'b0;
        end
        bus.in_valid       = 1'b0;
        bus.dm_rdata       = d;
        bus.dm_rdata_valid = 1'b1;
        bus.flush          = (flush_at == waits);
        check_val("stall_resp", bus.stall_req, 32'd1);
        if (!killed) exp_q.push_back(model_load(sel, a, rt, d, wen, wa));
        tick();
        bus.dm_rdata_valid = 1'b0;
        bus.flush          = 1'b0;
        bus.dm_rdata       = $urandom;
        check_val("load_done_valid", bus.wb_valid, {31'd0, !killed});
        check_val("stall_after", bus.stall_req, 32'd0);
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        repeat (3) tick();
        check_val("rst_wb_valid", bus.wb_valid, 32'd0);
        check_val("rst_stall", bus.stall_req, 32'd0);
        check_val("rst_ben", bus.wb_b_w_en, 32'd0);
        check_val("rst_wdata", bus.wb_wdata, 32'd0);
        check_val("rst_waddr", bus.wb_waddr, 32'd0);
        resetn = 1'b1;
        tick();

        // Non-load pass-through, including one that does not write.
        issue_nonload(32'h12345678, 5'd9, 1'b1);
        issue_nonload(32'hCAFEF00D, 5'd3, 1'b0);

        // Directed loads.
        do_load(3'd1, 2'd2, 32'h0, 32'h8899AABB, 5'd4, 1'b1, 3, -1, 1'b0);
        do_load(3'd2, 2'd2, 32'h0, 32'h8899AABB, 5'd5, 1'b1, 3, -1, 1'b0);
        do_load(3'd5, 2'd1, 32'hAABBCCDD, 32'h11223344, 5'd6, 1'b1, 1, -1, 1'b0);
        do_load(3'd6, 2'd1, 32'hAABBCCDD, 32'h11223344, 5'd7, 1'b1, 1, -1, 1'b0);
        do_load(3'd3, 2'd3, 32'h0, 32'h80017FFF, 5'd8, 1'b1, 0, -1, 1'b0);
        do_load(3'd4, 2'd2, 32'h0, 32'h80017FFF, 5'd10, 1'b1, 2, -1, 1'b0);
        do_load(3'd7, 2'd0, 32'h0, 32'hDEADBEEF, 5'd11, 1'b1, 1, -1, 1'b0);

        // Flush two cycles before the response, then a normal load.
        do_load(3'd0, 2'd0, 32'h0, 32'h55555555, 5'd12, 1'b1, 3, 1, 1'b0);
        do_load(3'd0, 2'd0, 32'h0, 32'h66666666, 5'd13, 1'b1, 2, -1, 1'b0);
        // Flush coincident with the response.
        do_load(3'd1, 2'd0, 32'h0, 32'h000000F0, 5'd14, 1'b1, 2, 2, 1'b0);
        check_val("flush_coinc_stall", bus.stall_req, 32'd0);

        // Flushed instructions in IDLE capture nothing; stray response ignored.
        bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.flush = 1'b1;
        tick();
        check_val("idle_flush_load_stall", bus.stall_req, 32'd0);
        bus.in_is_load = 1'b0;
        tick();
        check_val("idle_flush_nonload_valid", bus.wb_valid, 32'd0);
        idle_inputs();
        bus.dm_rdata_valid = 1'b1;
        tick();
        bus.dm_rdata_valid = 1'b0;
        check_val("idle_resp_valid", bus.wb_valid, 32'd0);
        check_val("idle_resp_stall", bus.stall_req, 32'd0);

        // Randomised loads with pipeline noise during the wait.
        for (int n = 0; n < 24; n++) begin
            do_load(3'($urandom), 2'($urandom), $urandom, $urandom, 5'($urandom),
                    1'($urandom), int'($urandom_range(0, 3)), -1, 1'b1);
        end

        // Reset held for two cycles while waiting on a load.
        bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_load_sel = 3'd0;
        bus.in_wen = 1'b1; bus.in_waddr = 5'd20;
        tick();
        bus.in_valid = 1'b0;
        check_val("pre_rst_stall", bus.stall_req, 32'd1);
        resetn = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        check_val("rst_wait_wb_valid", bus.wb_valid, 32'd0);
        check_val("rst_wait_stall", bus.stall_req, 32'd0);
        check_val("rst_wait_ben", bus.wb_b_w_en, 32'd0);
        bus.dm_rdata = 32'h12121212;
        bus.dm_rdata_valid = 1'b1;
        tick();
        bus.dm_rdata_valid = 1'b0;
        check_val("rst_late_resp_valid", bus.wb_valid, 32'd0);
        repeat (2) tick();

        check_val("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_wb_load_stage.md
Name: mem_wb_load_stage

Overview:
- Load-completion stage sitting between the MEM stage and register-file writeback.
- Handles both loads and non-load results:
  - Accepts each MEM-stage instruction and, for loads, waits for the data-memory response.
  - Aligns and extends the returned word, merging partial-word lwl/lwr data with the old rt value.
  - Non-load results pass through with the same one-cycle register latency.
- Drives the register-file write port (data, address, per-byte write enable) and a stall request back to the pipeline.

Parameters:
- DW, 32, data width; only 32 is supported.
- RW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- in_valid  in  1  MEM-stage instruction valid.
- in_is_load  in  1  instruction is a load.
- in_load_sel  in  3  load type: 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lwl, 6 lwr, 7 treated as lw.
- in_addr  in  2  effective address bits [1:0].
- in_rt_old  in  DW  current rt value, used for lwl/lwr merge.
- in_alu_res  in  DW  result for non-load instructions.
- in_wen  in  1  instruction writes the register file.
- in_waddr  in  RW  destination register.
- flush  in  1  kill the in-flight instruction.
- dm_rdata_valid  in  1  data-memory response strobe, single cycle.
- dm_rdata  in  DW  memory word, little-endian byte lanes.
- stall_req  out  1  hold upstream stages.
- wb_valid  out  1  writeback valid, one-cycle pulse per instruction.
- wb_we  out  1  register write enable.
- wb_waddr  out  RW  write address.
- wb_wdata  out  DW  fully merged write data.
- wb_b_w_en  out  4  per-byte write enable.

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE; wb_valid=0, wb_we=0, wb_waddr=0, wb_wdata=0, wb_b_w_en=4'b0000, stall_req=0. Reset mid-WAIT or mid-DRAIN abandons the in-flight load; any later response is ignored because the FSM is back in IDLE.
- FSM states: IDLE, WAIT, DRAIN.
- IDLE:
  - in_valid & !flush & !in_is_load → next cycle wb_valid=1, wb_we=in_wen, wb_wdata=in_alu_res, wb_b_w_en=4'b1111.
  - in_valid & !flush & in_is_load → capture load_sel, addr, rt_old, wen, waddr; go to WAIT.
  - in_valid & flush → nothing is captured.
- WAIT:
  - stall_req=1 combinationally; in_valid is ignored.
  - dm_rdata_valid & !flush → go to IDLE; next cycle wb_valid=1 with the computed result. Load latency = 1 cycle after dm_rdata_valid.
  - flush & !dm_rdata_valid → go to DRAIN.
  - flush & dm_rdata_valid in the same cycle → discard the data; go to IDLE with no wb_valid.
- DRAIN:
  - stall_req=1; waits for dm_rdata_valid, discards it, then goes to IDLE. No wb_valid is produced.
- dm_rdata_valid in IDLE is ignored.
- stall_req is 0 in IDLE.
- wb_valid=0 in every cycle without a completion; wb_we is forced to 0 whenever wb_valid=0.
- Byte selection, with a = captured addr and B(k) = dm_rdata[8k+7:8k]:
  - lb / lbu: B(a), sign- or zero-extended to 32 bits.
  - lh / lhu: halfword dm_rdata[16*a[1]+15 : 16*a[1]], sign- or zero-extended; a[0] is ignored.
  - lw: dm_rdata. wb_b_w_en=1111 for lw, lb, lbu, lh and lhu.
- lwl:
  - shifted = dm_rdata << 8a.
  - b_w_en by a: a=3 → 1000, a=2 → 1100, a=1 → 1110, a=0 → 1111.
- lwr:
  - shifted = dm_rdata >> 8(3−a).
  - b_w_en by a: a=3 → 1111, a=2 → 0111, a=1 → 0011, a=0 → 0001.
- lwl / lwr merge: wb_wdata byte k = shifted byte k if b_w_en[k]=1, else in_rt_old byte k. wb_b_w_en carries the same mask, so the write port may use either the merged data or the byte enables.
- All outputs except stall_req are registered.

Test Plan:
- Reset: hold resetn=0 for 2 cycles while state=WAIT → after the edge wb_valid=0, stall_req=0, wb_b_w_en=0000; a dm_rdata_valid pulse afterwards produces no wb_valid.
- Non-load: in_alu_res=0x12345678, in_waddr=9, in_wen=1 → next cycle wb_valid=1, wb_wdata=0x12345678, wb_waddr=9, wb_b_w_en=1111.
- lb, addr=2, dm_rdata=0x8899AABB, 3 wait cycles → stall_req=1 for those 3 cycles; wb_wdata=0xFFFFFF99 the cycle after the response.
- lbu with the same stimulus → wb_wdata=0x00000099.
- lwl, addr=1, dm_rdata=0x11223344, rt_old=0xAABBCCDD → wb_wdata=0x223344DD, wb_b_w_en=1110.
- lwr, addr=1, same data → wb_wdata=0xAABB1122, wb_b_w_en=0011.
- Flush in WAIT two cycles before the response → state=DRAIN with stall_req=1 until the response arrives; no wb_valid; the following load completes normally.
- Flush coincident with dm_rdata_valid → no wb_valid; the FSM returns to IDLE next cycle.
